valu_sequencer: RTL and testbench

Element-serial controller for the shared 21-bit scalar ALU in the vector execute stage. It accepts one vector instruction (funct, length, two packed operand vectors) and issues one element per cycle to the ALU. It collects each element result into a packed result vector and reports completion with a done pulse. The ALU sits outside this block and is driven through the alu_* ports.

---
 rtl/vproc_pkg.sv | 30 +++
 rtl/valu_sequencer.sv | 171 +++++++++++++++++
 tb/tb_valu_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/vproc_pkg.sv
// Shared types and constants for the vector execute stage.
package vproc_pkg;

  localparam int DW    = 21;
  localparam int LANES = 8;

  // ALU function codes understood by the shared scalar ALU
  typedef enum logic [2:0] {
    FN_MOV = 3'b000,
    FN_ADD = 3'b010,
    FN_SUB = 3'b011,
    FN_MUL = 3'b111
  } funct_e;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  // True for the function codes the ALU implements
  function automatic logic is_legal_funct(input logic [2:0] f);
    case (f)
      FN_MOV, FN_ADD, FN_SUB, FN_MUL: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/valu_sequencer.sv
// Element-serial sequencer for the shared scalar ALU: latches one vector
// instruction, issues one element per cycle and packs the results.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | waiting for start; inputs sampled here only
// S_RUN  | element idx_q on the ALU ports, result written each edge
// S_DONE | one-cycle done pulse; vec_r and err stay valid afterwards
module valu_sequencer
  import vproc_pkg::*;
#(
  parameter int LANES = vproc_pkg::LANES,
  parameter int DW    = vproc_pkg::DW,
  parameter int LW    = $clog2(LANES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          funct,
  input  logic [LW-1:0]       vlen,
  input  logic [LANES*DW-1:0] vec_a,
  input  logic [LANES*DW-1:0] vec_b,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [LANES*DW-1:0] vec_r,
  output logic                alu_flag,
  output logic [2:0]          alu_funct,
  output logic [DW-1:0]       alu_op1,
  output logic [DW-1:0]       alu_op2,
  input  logic [DW-1:0]       alu_result
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef logic [DW-1:0] elem_t;

  state_e          state_q, state_d;
  logic [2:0]      funct_q, funct_d;
  logic [LW-1:0]   len_q,   len_d;
  logic [LW-1:0]   idx_q,   idx_d;
  logic            err_q,   err_d;
  elem_t           a_q [LANES];
  elem_t           a_d [LANES];
  elem_t           b_q [LANES];
  elem_t           b_d [LANES];
  elem_t           r_q [LANES];
  elem_t           r_d [LANES];

  logic [LW-1:0]   len_eff;
  logic [IW-1:0]   sel;

  // idx_q never exceeds LANES-1, so the low bits address the lane directly
  assign sel = idx_q[IW-1:0];

  // Clamp the requested length to the number of lanes
  always_comb begin
    len_eff = vlen;
    if (vlen > LW'(LANES)) begin
      len_eff = LW'(LANES);
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      funct_q <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        r_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      funct_q <= funct_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      for (int i = 0; i < LANES; i++) begin
        a_q[i] <= a_d[i];
        b_q[i] <= b_d[i];
        r_q[i] <= r_d[i];
      end
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    funct_d = funct_q;
    len_d   = len_q;
    idx_d   = idx_q;
    err_d   = err_q;
    for (int i = 0; i < LANES; i++) begin
      a_d[i] = a_q[i];
      b_d[i] = b_q[i];
      r_d[i] = r_q[i];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          funct_d = funct;
          len_d   = len_eff;
          idx_d   = '0;
          for (int i = 0; i < LANES; i++) begin
            a_d[i] = vec_a[i*DW +: DW];
            b_d[i] = vec_b[i*DW +: DW];
            r_d[i] = '0;
          end
          if (!is_legal_funct(funct)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (len_eff == '0) begin
            err_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        r_d[sel] = alu_result;
        // Exit is checked first so idx_q stops at len-1 and never wraps
        if (idx_q == len_q - LW'(1)) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + LW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status and ALU drive; operands are forced to zero outside RUN
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    err       = err_q;
    alu_flag  = (state_q == S_RUN);
    alu_funct = funct_q;
    alu_op1   = '0;
    alu_op2   = '0;
    if (state_q == S_RUN) begin
      alu_op1 = a_q[sel];
      alu_op2 = b_q[sel];
    end
  end

  // Pack the result lanes onto the output bus
  always_comb begin
    vec_r = '0;
    for (int i = 0; i < LANES; i++) begin
      vec_r[i*DW +: DW] = r_q[i];
    end
  end

endmodule

// File: tb/tb_valu_sequencer.sv
// Self-checking bench for valu_sequencer with a behavioural ALU attached.
module tb_valu_sequencer;

  localparam int LANES = 8;
  localparam int DW    = 21;
  localparam int LW    = 4;
  localparam int VW    = LANES * DW;

  logic          clk;
  logic          rst;
  logic          start;
  logic [2:0]    funct;
  logic [LW-1:0] vlen;
  logic [VW-1:0] vec_a;
  logic [VW-1:0] vec_b;
  logic          busy;
  logic          done;
  logic          err;
  logic [VW-1:0] vec_r;
  logic          alu_flag;
  logic [2:0]    alu_funct;
  logic [DW-1:0] alu_op1;
  logic [DW-1:0] alu_op2;
  logic [DW-1:0] alu_result;

  int n_chk = 0;
  int n_err = 0;

  valu_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .funct      (funct),
    .vlen       (vlen),
    .vec_a      (vec_a),
    .vec_b      (vec_b),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .vec_r      (vec_r),
    .alu_flag   (alu_flag),
    .alu_funct  (alu_funct),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_result (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational scalar ALU sitting beside the sequencer
  always_comb begin
    case (alu_funct)
      3'b000:  alu_result = alu_op2;
      3'b010:  alu_result = alu_op1 + alu_op2;
      3'b011:  alu_result = alu_op1 - alu_op2;
      3'b111:  alu_result = alu_op1 * alu_op2;
      default: alu_result = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic legal(input logic [2:0] f);
    return (f == 3'b000) || (f == 3'b010) || (f == 3'b011) || (f == 3'b111);
  endfunction

  // Reference element result: plain integer arithmetic reduced mod 2^DW
  function automatic logic [DW-1:0] ref_elem(input logic [2:0] f, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    longint unsigned m, x, y, r;
    m = 64'd1 << DW;
    x = 64'(a);
    y = 64'(b);
    case (f)
      3'b000:  r = y;
      3'b010:  r = (x + y) % m;
      3'b011:  r = (x + m - y) % m;
      3'b111:  r = (x * y) % m;
      default: r = 0;
    endcase
    return r[DW-1:0];
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  // Issue one instruction at the current negedge and follow it to completion.
  // p1/p2 are cycles in which a stray start (with scrambled inputs) is pulsed.
  task automatic run_instr(input logic [2:0] f, input logic [LW-1:0] vl,
                           input logic [VW-1:0] va, input logic [VW-1:0] vb,
                           input int p1, input int p2);
    int            len, exp_done, cyc;
    logic          ok, got;
    logic [VW-1:0] exp_r;
    logic          flag_exp;

    len      = (int'(vl) > LANES) ? LANES : int'(vl);
    ok       = legal(f);
    exp_done = (!ok || len == 0) ? 1 : len + 1;
    exp_r    = '0;
    if (ok) begin
      for (int i = 0; i < len; i++) exp_r[i*DW +: DW] = ref_elem(f, va[i*DW +: DW], vb[i*DW +: DW]);
    end

    start = 1'b1; funct = f; vlen = vl; vec_a = va; vec_b = vb;
    @(negedge clk);
    cyc = 1;
    got = 1'b0;
    while (!got && cyc <= 20) begin
      start    = 1'b0;
      flag_exp = ok && (len != 0) && (cyc <= len);
      chk("alu_flag", VW'(alu_flag), VW'(flag_exp));
      chk("busy", VW'(busy), VW'(1));
      if (flag_exp) begin
        chk("alu_funct", VW'(alu_funct), VW'(f));
        chk("alu_op1", VW'(alu_op1), VW'(va[(cyc-1)*DW +: DW]));
        chk("alu_op2", VW'(alu_op2), VW'(vb[(cyc-1)*DW +: DW]));
      end else begin
        chk("alu_op1_idle", VW'(alu_op1), VW'(0));
      end
      if (cyc == p1 || cyc == p2) begin
        start = 1'b1;
        funct = 3'($urandom);
        vlen  = LW'($urandom);
        vec_a = rand_vec();
        vec_b = rand_vec();
      end
      if (done) begin
        got = 1'b1;
        chk("done_cycle", VW'(cyc), VW'(exp_done));
        chk("err", VW'(err), VW'(!ok));
        chk("vec_r", vec_r, exp_r);
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("done_seen", VW'(got), VW'(1));
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse_end", VW'(done), VW'(0));
    chk("busy_after", VW'(busy), VW'(0));
    chk("vec_r_held", vec_r, exp_r);
    chk("err_held", VW'(err), VW'(!ok));
  endtask

  initial begin
    logic [VW-1:0] va, vb;

    rst = 1'b1; start = 1'b0; funct = '0; vlen = '0; vec_a = '0; vec_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", VW'(busy), VW'(0));
    chk("rst_done", VW'(done), VW'(0));
    chk("rst_flag", VW'(alu_flag), VW'(0));
    chk("rst_vec_r", vec_r, VW'(0));
    rst = 1'b0;
    @(negedge clk);

    // ADD, 4 elements
    va = '0; vb = '0;
    for (int i = 0; i < 4; i++) begin
      va[i*DW +: DW] = DW'(i + 1);
      vb[i*DW +: DW] = DW'(10 * (i + 1));
    end
    run_instr(3'b010, 4'd4, va, vb, 0, 0);

    // SUB wrap and MUL truncation
    run_instr(3'b011, 4'd1, VW'(0), VW'(1), 0, 0);
    run_instr(3'b111, 4'd1, VW'(21'h1000), VW'(21'h1000), 0, 0);

    // Illegal function, zero length
    run_instr(3'b001, 4'd8, rand_vec(), rand_vec(), 0, 0);
    run_instr(3'b010, 4'd0, rand_vec(), rand_vec(), 0, 0);

    // MOV with clamped length
    vb = '0;
    for (int i = 0; i < LANES; i++) vb[i*DW +: DW] = DW'(i + 100);
    run_instr(3'b000, 4'd15, rand_vec(), vb, 0, 0);

    // Stray starts in RUN and DONE, then back-to-back acceptance
    run_instr(3'b010, 4'd8, rand_vec(), rand_vec(), 2, 9);
    run_instr(3'b011, 4'd3, rand_vec(), rand_vec(), 0, 0);

    // Asynchronous reset mid-RUN at index 3
    va = rand_vec();
    start = 1'b1; funct = 3'b010; vlen = 4'd8; vec_a = va; vec_b = rand_vec();
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_op1", VW'(alu_op1), VW'(va[3*DW +: DW]));
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", VW'(busy), VW'(0));
    chk("arst_flag", VW'(alu_flag), VW'(0));
    chk("arst_op1", VW'(alu_op1), VW'(0));
    chk("arst_op2", VW'(alu_op2), VW'(0));
    chk("arst_funct", VW'(alu_funct), VW'(0));
    chk("arst_vec_r", vec_r, VW'(0));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("arst_no_done", VW'(done), VW'(0));
    end
    rst = 1'b0;
    @(negedge clk);
    run_instr(3'b010, 4'd5, rand_vec(), rand_vec(), 0, 0);

    // Randomized instructions
    for (int n = 0; n < 25; n++) begin
      run_instr(3'($urandom_range(0, 7)), LW'($urandom_range(0, 15)), rand_vec(), rand_vec(),
                int'($urandom_range(0, 10)), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
